inc_arbiter: RTL and testbench
==============================

INC_ARBITER -- requirements
Module: inc_arbiter

Interface
REQ-001 Parameter: WIDTH, 16, datapath width of operand and result; only 16 is supported.
REQ-002 Port: clk  input  1  single clock; all state updates on rising edge.
REQ-003 Port: reset  input  1  asynchronous, active-high; clears all state immediately on assertion.
REQ-004 Port: req_valid  input  4  per-requester operand-valid flag; bit i belongs to requester i.
REQ-005 Port: req_a  input  64  packed operands; requester i at bits [16*i+15:16*i].
REQ-006 Port: req_ready  output  4  one-hot grant; bit i high when requester i's operand is accepted this cycle.
REQ-007 Port: rsp_valid  output  1  result register holds a valid result.
REQ-008 Port: rsp_ready  input  1  consumer accepts the result this cycle.
REQ-009 Port: rsp_out  output  16  registered result, equal to the granted operand + 1.
REQ-010 Port: rsp_id  output  2  index of the requester that produced rsp_out.
REQ-011 Port: rsp_wrap  output  1  high when the granted operand was 16'hFFFF.
REQ-012 Port: grant_count  output  16  total accepted requests since reset.

Function
REQ-013 The block shall share one Inc16 instance between four requesters; the mux-selected operand drives Inc16 input a.
REQ-014 State machine EMPTY/FULL shall track the result register: EMPTY when rsp_valid=0, FULL when rsp_valid=1.
REQ-015 Accept condition: accept = (any req_valid) && (EMPTY || rsp_ready).
REQ-016 Arbitration shall be round-robin: search starts at (last_grant+1) mod 4, ascending with wrap, and picks the first requester with req_valid set.
REQ-017 req_ready shall be combinational, one-hot when accept=1, all zero otherwise; at most one bit is ever set.
REQ-018 req_ready shall not depend on the requester's own req_valid through a path other than the arbitration, so there is no combinational loop back to any requester.
REQ-019 On accept, at the clock edge: rsp_out<=Inc16(out), rsp_id<=winner, rsp_wrap<=(operand==16'hFFFF), rsp_valid<=1, last_grant<=winner, grant_count<=grant_count+1.
REQ-020 Latency: a result shall be visible exactly 1 cycle after its accept edge.
REQ-021 Throughput: one result per cycle when rsp_ready is held high (FULL with rsp_ready=1 and accept performs a simultaneous drain and refill).
REQ-022 FULL with rsp_ready=0 is a stall: req_ready=0, and rsp_out, rsp_id and rsp_wrap shall hold stable.
REQ-023 FULL with rsp_ready=1 and no req_valid shall clear rsp_valid (transition to EMPTY); rsp_out keeps its last value.
REQ-024 EMPTY with rsp_ready=1 and no request shall change no state.
REQ-025 Arithmetic wrap: 16'hFFFF+1 shall give rsp_out=16'h0000 with rsp_wrap=1; there is no other carry output.
REQ-026 grant_count shall wrap modulo 2^16 (16'hFFFF -> 16'h0000).
REQ-027 last_grant shall update only on accept; stalls and idle cycles preserve fairness order.
REQ-028 A requester that drops req_valid before it is granted loses no state; no request is latched before it is granted.

Reset
REQ-029 While reset=1: rsp_valid=0, rsp_out=0, rsp_id=0, rsp_wrap=0, grant_count=0, req_ready=0, last_grant=3 (first priority goes to requester 0).
REQ-030 Reset asserted mid-operation shall discard any pending result without completing it; after reset deasserts, the first accept is no earlier than the next rising edge.

Verification
REQ-031 Reset, then req_valid=4'b0001, req_a[0]=16'h0004 -> next cycle rsp_valid=1, rsp_out=16'h0005, rsp_id=0, rsp_wrap=0, grant_count=1.
REQ-032 req_valid=4'b1111 held, rsp_ready=1 for 5 cycles -> grants in order 0,1,2,3,0; one result per cycle; grant_count=5.
REQ-033 req_a[2]=16'hFFFF, only requester 2 valid -> rsp_out=16'h0000, rsp_id=2, rsp_wrap=1.
REQ-034 FULL with rsp_ready=0 for 3 cycles, all requesters valid -> req_ready=0 throughout, rsp_out held; rsp_ready=1 -> drain and next grant go to (last+1) in the same cycle.
REQ-035 Reset pulsed while FULL with a pending result -> rsp_valid=0 and grant_count=0 immediately; the next grant after release goes to requester 0.
REQ-036 Every check shall compare with !== (4-state), so that X or Z on rsp_out, rsp_valid or req_ready is flagged as a failure.

Source files
------------

// File: rtl/inc_arbiter.sv
// Four-requester round-robin front end sharing one 16-bit incrementer.
// Ports: clk, reset (async high), req_valid/req_a/req_ready (requests),
//        rsp_valid/rsp_ready/rsp_out/rsp_id/rsp_wrap (result), grant_count.
module inc_arbiter #(
    parameter int WIDTH = 16
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [3:0]         req_valid,
    input  logic [4*WIDTH-1:0] req_a,
    output logic [3:0]         req_ready,
    output logic               rsp_valid,
    input  logic               rsp_ready,
    output logic [WIDTH-1:0]   rsp_out,
    output logic [1:0]         rsp_id,
    output logic               rsp_wrap,
    output logic [15:0]        grant_count
);

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } state_t;

    state_t           state;
    logic [1:0]       last_grant;
    logic [1:0]       winner;
    logic [1:0]       idx;
    logic             found;
    logic             accept;
    logic [WIDTH-1:0] operand;
    logic [WIDTH-1:0] inc_out;
    logic             inc_wrap;

    // Round-robin search: offsets 1..4 from last_grant; offset 4 wraps
    // back to last_grant itself so it is considered last.
    always_comb begin
        found  = 1'b0;
        winner = last_grant;
        idx    = '0;
        for (int k = 1; k <= 4; k++) begin
            idx = last_grant + 2'(k);
            if (!found && req_valid[idx]) begin
                found  = 1'b1;
                winner = idx;
            end
        end
    end

    // Reset gates accept so no grant is offered while reset is held.
    assign accept = found && !reset
                    && (state == EMPTY || rsp_ready);

    assign req_ready = accept ? (4'b0001 << winner) : 4'b0000;

    // Shared incrementer fed by the granted operand.
    assign operand  = req_a[winner*WIDTH +: WIDTH];
    assign inc_out  = operand + WIDTH'(1);
    assign inc_wrap = &operand;

    assign rsp_valid = (state == FULL);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= EMPTY;
            last_grant  <= 2'd3;
            rsp_out     <= '0;
            rsp_id      <= '0;
            rsp_wrap    <= 1'b0;
            grant_count <= '0;
        end else begin
            case (state)
                EMPTY: begin
                    if (accept) begin
                        state <= FULL;
                    end
                end
                FULL: begin
                    if (rsp_ready && !accept) begin
                        state <= EMPTY;
                    end
                end
                default: state <= EMPTY;
            endcase
            if (accept) begin
                rsp_out     <= inc_out;
                rsp_id      <= winner;
                rsp_wrap    <= inc_wrap;
                last_grant  <= winner;
                grant_count <= grant_count + 16'd1;
            end
        end
    end

endmodule

// File: tb/tb_inc_arbiter.sv
// Self-checking bench for inc_arbiter: reference model plus per-cycle
// comparison, and directed scenarios with literal expectations.
module tb_inc_arbiter;

    logic        clk;
    logic        reset;
    logic [3:0]  req_valid;
    logic [63:0] req_a;
    logic [3:0]  req_ready;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [15:0] rsp_out;
    logic [1:0]  rsp_id;
    logic        rsp_wrap;
    logic [15:0] grant_count;

    int checks   = 0;
    int failures = 0;

    inc_arbiter #(.WIDTH(16)) dut (
        .clk         (clk),
        .reset       (reset),
        .req_valid   (req_valid),
        .req_a       (req_a),
        .req_ready   (req_ready),
        .rsp_valid   (rsp_valid),
        .rsp_ready   (rsp_ready),
        .rsp_out     (rsp_out),
        .rsp_id      (rsp_id),
        .rsp_wrap    (rsp_wrap),
        .grant_count (grant_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    // Reference model: who wins is the first valid requester after
    // the previous winner, counting upward modulo 4.
    int          m_last;
    bit          m_valid;
    logic [15:0] m_out;
    int          m_id;
    bit          m_wrap;
    int          m_count;

    function automatic int pick(input logic [3:0] v, input int last);
        for (int k = 1; k <= 4; k++) begin
            if (v[(last + k) % 4] === 1'b1) return (last + k) % 4;
        end
        return -1;
    endfunction

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            m_last  = 3;
            m_valid = 0;
            m_out   = 16'h0000;
            m_id    = 0;
            m_wrap  = 0;
            m_count = 0;
        end else begin
            int w;
            logic [15:0] op;
            w = pick(req_valid, m_last);
            if (w >= 0 && (!m_valid || rsp_ready)) begin
                op      = req_a[w*16 +: 16];
                m_out   = 16'((32'(op) + 1) % 65536);
                m_wrap  = (op == 16'hFFFF);
                m_id    = w;
                m_last  = w;
                m_valid = 1;
                m_count = (m_count + 1) % 65536;
            end else if (m_valid && rsp_ready) begin
                m_valid = 0;
            end
        end
    end

    // Per-cycle comparison against the model, away from the active edge.
    always @(negedge clk) begin
        int w;
        logic [3:0] exp_ready;
        w = pick(req_valid, m_last);
        exp_ready = 4'b0000;
        if (!reset && w >= 0 && (!m_valid || rsp_ready))
            exp_ready = 4'(1 << w);
        chk("model_req_ready", 32'(req_ready), 32'(exp_ready));
        chk("model_rsp_valid", 32'(rsp_valid), 32'(m_valid));
        chk("model_rsp_out", 32'(rsp_out), 32'(m_out));
        chk("model_rsp_id", 32'(rsp_id), 32'(m_id));
        chk("model_rsp_wrap", 32'(rsp_wrap), 32'(m_wrap));
        chk("model_grant_count", 32'(grant_count), 32'(m_count));
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset     = 1'b1;
        req_valid = 4'b1111;
        rsp_ready = 1'b0;
        req_a     = {16'h0400, 16'h0300, 16'h0200, 16'h0100};
        tick();
        tick();
        chk("rst_req_ready", 32'(req_ready), 32'h0);
        chk("rst_rsp_valid", 32'(rsp_valid), 32'h0);
        chk("rst_rsp_out", 32'(rsp_out), 32'h0);
        chk("rst_grant_count", 32'(grant_count), 32'h0);

        // Single request from requester 0.
        reset     = 1'b0;
        req_valid = 4'b0001;
        req_a     = {16'h0400, 16'h0300, 16'h0200, 16'h0004};
        rsp_ready = 1'b1;
        #1;
        chk("single_req_ready", 32'(req_ready), 32'h1);
        tick();
        chk("single_rsp_valid", 32'(rsp_valid), 32'h1);
        chk("single_rsp_out", 32'(rsp_out), 32'h0005);
        chk("single_rsp_id", 32'(rsp_id), 32'h0);
        chk("single_rsp_wrap", 32'(rsp_wrap), 32'h0);
        chk("single_count", 32'(grant_count), 32'h1);

        // Fresh reset, then all requesters held valid for 5 cycles.
        reset = 1'b1;
        #1;
        reset     = 1'b0;
        req_valid = 4'b1111;
        req_a     = {16'h0400, 16'h0300, 16'h0200, 16'h0100};
        #1;
        for (int k = 0; k < 5; k++) begin
            chk("rr_req_ready", 32'(req_ready), 32'(1 << (k % 4)));
            tick();
            chk("rr_rsp_id", 32'(rsp_id), 32'(k % 4));
            chk("rr_rsp_out", 32'(rsp_out),
                32'(16'h0100 * (k % 4 + 1) + 1));
            chk("rr_rsp_valid", 32'(rsp_valid), 32'h1);
        end
        chk("rr_count", 32'(grant_count), 32'd5);

        // Wrap-around operand on requester 2.
        req_valid = 4'b0100;
        req_a     = {16'h0400, 16'hFFFF, 16'h0200, 16'h0100};
        tick();
        chk("wrap_rsp_out", 32'(rsp_out), 32'h0000);
        chk("wrap_rsp_id", 32'(rsp_id), 32'h2);
        chk("wrap_rsp_wrap", 32'(rsp_wrap), 32'h1);
        chk("wrap_count", 32'(grant_count), 32'd6);

        // Stall for 3 cycles with everyone requesting.
        rsp_ready = 1'b0;
        req_valid = 4'b1111;
        for (int k = 0; k < 3; k++) begin
            #1;
            chk("stall_req_ready", 32'(req_ready), 32'h0);
            tick();
            chk("stall_rsp_out", 32'(rsp_out), 32'h0000);
            chk("stall_rsp_id", 32'(rsp_id), 32'h2);
            chk("stall_rsp_wrap", 32'(rsp_wrap), 32'h1);
        end
        rsp_ready = 1'b1;
        #1;
        chk("unstall_req_ready", 32'(req_ready), 32'h8);
        tick();
        chk("unstall_rsp_id", 32'(rsp_id), 32'h3);
        chk("unstall_rsp_out", 32'(rsp_out), 32'h0401);
        chk("unstall_count", 32'(grant_count), 32'd7);

        // Drain, then an idle cycle that must change nothing.
        req_valid = 4'b0000;
        tick();
        chk("drain_rsp_valid", 32'(rsp_valid), 32'h0);
        chk("drain_rsp_out", 32'(rsp_out), 32'h0401);
        tick();
        chk("idle_rsp_valid", 32'(rsp_valid), 32'h0);
        chk("idle_count", 32'(grant_count), 32'd7);

        // Reset while a result is pending.
        req_valid = 4'b0010;
        tick();
        chk("pend_rsp_id", 32'(rsp_id), 32'h1);
        chk("pend_rsp_valid", 32'(rsp_valid), 32'h1);
        rsp_ready = 1'b0;
        req_valid = 4'b1111;
        #1;
        reset = 1'b1;
        #1;
        chk("midrst_rsp_valid", 32'(rsp_valid), 32'h0);
        chk("midrst_count", 32'(grant_count), 32'h0);
        chk("midrst_req_ready", 32'(req_ready), 32'h0);
        tick();
        reset     = 1'b0;
        rsp_ready = 1'b1;
        #1;
        chk("post_rst_req_ready", 32'(req_ready), 32'h1);
        tick();
        chk("post_rst_rsp_id", 32'(rsp_id), 32'h0);
        chk("post_rst_rsp_out", 32'(rsp_out), 32'h0101);
        chk("post_rst_count", 32'(grant_count), 32'h1);

        req_valid = 4'b0000;
        tick();
        tick();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
